// File: rtl/io_in_device.sv
// rtl/io_in_device.sv - input-device byte source: FIFO feeding a 4-phase in_dev_hs/in_dev_ack handshake
module io_in_device #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 255
) (
   input  logic          g_clk,
   input  logic          g_clr,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic [7:0]    input_bus,
   output logic          in_dev_hs,
   input  logic          in_dev_ack,
   output logic          xfer_done,
   output logic          overflow,
   output logic          timeout
);

   typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

   localparam logic [7:0]  TMAX     = 8'(TIMEOUT);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic [7:0]    tcnt;
   logic          pop;
   logic          push;

   // The head entry is only released once the processor has acknowledged it,
   // so a push into a full FIFO is still accepted on that same cycle.
   assign pop   = (state == REQ) && in_dev_ack;
   assign push  = wr_en && (!full || pop);
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);
   assign count = cnt;

   // FIFO storage; when full and popping, wr_ptr equals rd_ptr but the head
   // byte has already been latched onto input_bus, so overwriting it is safe.
   always_ff @(posedge g_clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + (AW + 1)'(1);
         end else if (pop && !push) begin
            cnt <= cnt - (AW + 1)'(1);
         end
         if (wr_en && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Handshake FSM with registered bus/request/done outputs and edge timeout.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         state     <= IDLE;
         input_bus <= 8'h00;
         in_dev_hs <= 1'b0;
         xfer_done <= 1'b0;
         timeout   <= 1'b0;
         tcnt      <= 8'h00;
      end else begin
         xfer_done <= 1'b0;
         case (state)
            IDLE: begin
               in_dev_hs <= 1'b0;
               tcnt      <= 8'h00;
               if (!empty) begin
                  input_bus <= mem[rd_ptr];
                  state     <= SETUP;
               end
            end
            SETUP: begin
               in_dev_hs <= 1'b1;
               tcnt      <= 8'h00;
               state     <= REQ;
            end
            REQ: begin
               if (in_dev_ack) begin
                  in_dev_hs <= 1'b0;
                  tcnt      <= 8'h00;
                  state     <= RELEASE;
               end else if (tcnt != TMAX) begin
                  tcnt <= tcnt + 8'd1;
                  if (tcnt + 8'd1 == TMAX) begin
                     timeout <= 1'b1;
                  end
               end
            end
            RELEASE: begin
               if (!in_dev_ack) begin
                  xfer_done <= 1'b1;
                  tcnt      <= 8'h00;
                  state     <= IDLE;
               end else if (tcnt != TMAX) begin
                  tcnt <= tcnt + 8'd1;
                  if (tcnt + 8'd1 == TMAX) begin
                     timeout <= 1'b1;
                  end
               end
            end
            default: begin
               in_dev_hs <= 1'b0;
               tcnt      <= 8'h00;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/io_in_device.md
Name: io_in_device

Overview:
Input-device side of the processor's in_dev_hs/in_dev_ack byte handshake. It sources bytes that the processor consumes over input_bus.
- A host or bench pushes bytes into an internal FIFO.
- The block presents each byte on input_bus and raises in_dev_hs.
- It completes a 4-phase handshake against the processor's in_dev_ack.
- It sits outside the processor, in the testbench or board top, wired directly to the processor's input_bus, in_dev_hs and in_dev_ack.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 2, FIFO pointer width; log2(DEPTH).
TIMEOUT, 255, cycles to wait on a handshake edge before flagging timeout; 8-bit counter.

Ports:
g_clk  in  1  system clock; all state updates on the rising edge.
g_clr  in  1  reset; asynchronous, active-low.
wr_en  in  1  push wr_data into the FIFO this cycle.
wr_data  in  8  byte to enqueue.
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
count  out  AW+1  current FIFO occupancy.
input_bus  out  8  byte presented to the processor; registered.
in_dev_hs  out  1  data-valid request to the processor; registered; active-high.
in_dev_ack  in  1  processor acknowledge; active-high.
xfer_done  out  1  one-cycle pulse when a byte has been fully handed over.
overflow  out  1  sticky flag: a push was attempted while full.
timeout  out  1  sticky flag: a handshake edge took longer than TIMEOUT cycles.

Behaviour:
- Reset (g_clr=0, asynchronous):
  - FIFO pointers and count cleared; empty=1, full=0.
  - input_bus=8'h00, in_dev_hs=0, xfer_done=0, overflow=0, timeout=0.
  - FSM goes to IDLE; timeout counter cleared.
  - Reset mid-transfer drops in_dev_hs immediately and discards the in-flight byte and all queued bytes.
- FIFO:
  - Push when wr_en=1 and not full.
  - wr_en=1 while full: data dropped, overflow set.
  - Pop happens internally, only on the REQ->RELEASE transition.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, REQ, RELEASE.
- IDLE:
  - in_dev_hs=0.
  - If !empty: latch FIFO head into input_bus, go to SETUP.
  - in_dev_ack is ignored in IDLE.
- SETUP:
  - Holds input_bus stable for one cycle of setup time.
  - Next cycle: in_dev_hs<=1, go to REQ.
- REQ:
  - in_dev_hs=1; input_bus held constant.
  - On in_dev_ack=1 (sampled): in_dev_hs<=0, pop FIFO, go to RELEASE.
  - First-byte latency: byte visible one cycle after the push; in_dev_hs rises the cycle after that.
- RELEASE:
  - in_dev_hs=0; input_bus still held.
  - On in_dev_ack=0: pulse xfer_done for one cycle, go to IDLE.
  - Back-to-back bytes therefore cost a minimum of 4 cycles each (IDLE, SETUP, REQ, RELEASE).
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle spent in REQ or RELEASE; saturates at TIMEOUT.
  - On reaching TIMEOUT, timeout is set (sticky).
  - The FSM keeps waiting; no abort.
- Sticky flags (overflow, timeout) clear only on reset.
- in_dev_ack high on entry to REQ, because the processor holds ack high: accepted on the first REQ cycle. The next handshake still requires ack to fall first, via RELEASE.
- input_bus keeps the last byte after the transfer completes until the next byte is latched.

Test Plan:
- Reset: hold g_clr=0, then release.
  -> input_bus=00, in_dev_hs=0, empty=1, count=0, flags 0.
- Single byte: push 8'h0A; responder asserts ack 2 cycles after hs, releases 1 cycle after hs falls.
  -> input_bus=0A one cycle after push; hs high the following cycle; one xfer_done pulse; empty=1.
- Fill and burst: push 8'h11, 22, 33, 44 on consecutive cycles; push 8'h55.
  -> full=1, 55 dropped, overflow=1.
  -> With an immediate-ack responder, bytes appear in order 11, 22, 33, 44 at 4-cycle spacing; four xfer_done pulses.
- Simultaneous push/pop: while full, push on the REQ->RELEASE cycle.
  -> Push accepted, count stays 4, overflow not set by that push.
- Timeout: push 8'hA5, hold ack=0 for 300 cycles.
  -> timeout=1 at cycle 255 of REQ, hs still 1, input_bus=A5.
  -> Then ack=1, ack=0 completes the transfer normally.
- Reset mid-transfer: push 2 bytes, assert g_clr=0 during REQ.
  -> hs=0 asynchronously, count=0, input_bus=00; no xfer_done after release.
